caterpillar_rules: RTL and testbench

- Rule-evaluation engine for the caterpillar game.
- Stores a caterpillar body of up to 8 segments, each one of 4 colors. Segments are appended and erased one at a time.
- Continuously reports which of 20 fixed rules the current body satisfies.
- Sits between the button/game controller (which drives update/erase/color) and the display/scoring logic (which reads segments and the rule vector).

---
 rtl/caterpillar_rules.sv | 123 ++++++++++++
 tb/tb_caterpillar_rules.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/caterpillar_rules.sv
// Caterpillar game rule engine: holds a body of up to 8 two-bit colored segments
// and continuously evaluates 20 fixed rules over the current body.
module caterpillar_rules (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        update,
    input  logic        erase,
    input  logic [1:0]  color,
    input  logic [2:0]  read_pos,
    output logic        empty,
    output logic        full,
    output logic [19:0] valid,
    output logic [1:0]  read_val,
    output logic        read_over
);

    logic [3:0]       len_q;
    logic [3:0]       len_d;
    logic [7:0][1:0]  body_q;
    logic [7:0][1:0]  body_d;

    logic [2:0]       last_idx_s;
    logic [7:0]       in_body_s;
    logic [3:0]       present_s;
    logic [2:0]       distinct_s;
    logic             adj_eq_s;
    logic             not_same_s;
    logic             dec_s;
    logic             inc_s;
    logic             pal_ok_s;

    assign empty      = (len_q == 4'd0);
    assign full       = (len_q == 4'd8);
    // Wraps to 7 when len is 8; only meaningful while the body is non-empty.
    assign last_idx_s = len_q[2:0] - 3'd1;

    // Next-state: erase wins over update; guards keep len within 0..8.
    always_comb begin
        len_d  = len_q;
        body_d = body_q;
        if (erase && !empty) begin
            len_d              = len_q - 4'd1;
            body_d[last_idx_s] = 2'd0;
        end else if (update && !full) begin
            len_d                = len_q + 4'd1;
            body_d[len_q[2:0]]   = color;
        end else begin
            len_d  = len_q;
            body_d = body_q;
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q  <= 4'd0;
            body_q <= '0;
        end else begin
            len_q  <= len_d;
            body_q <= body_d;
        end
    end

    // Per-segment occupancy mask so stale storage never feeds the rules.
    always_comb begin
        in_body_s = 8'h00;
        for (int i = 0; i < 8; i++) begin
            in_body_s[i] = (4'(i) < len_q);
        end
    end

    // Scan the occupied segments for color presence, ordering and symmetry.
    always_comb begin
        present_s  = 4'b0000;
        adj_eq_s   = 1'b0;
        not_same_s = 1'b0;
        dec_s      = 1'b0;
        inc_s      = 1'b0;
        pal_ok_s   = 1'b1;
        for (int i = 0; i < 8; i++) begin
            present_s = present_s | ({3'b000, in_body_s[i]} << body_q[i]);
            pal_ok_s  = pal_ok_s & (~in_body_s[i] |
                        (body_q[i] == body_q[last_idx_s - 3'(i)]));
        end
        for (int i = 1; i < 8; i++) begin
            adj_eq_s   = adj_eq_s   | (in_body_s[i] & (body_q[i] == body_q[i-1]));
            not_same_s = not_same_s | (in_body_s[i] & (body_q[i] != body_q[0]));
            dec_s      = dec_s      | (in_body_s[i] & (body_q[i] <  body_q[i-1]));
            inc_s      = inc_s      | (in_body_s[i] & (body_q[i] >  body_q[i-1]));
        end
        distinct_s = 3'(present_s[0]) + 3'(present_s[1]) +
                     3'(present_s[2]) + 3'(present_s[3]);
    end

    // Assemble the rule vector; head/tail rules are vacuously true when empty.
    always_comb begin
        valid      = 20'h00000;
        valid[3:0] = ~present_s;
        for (int k = 0; k < 4; k++) begin
            valid[4+k] = empty | (body_q[0] == 2'(k));
            valid[8+k] = empty | (body_q[last_idx_s] == 2'(k));
        end
        valid[12] = ~adj_eq_s;
        valid[13] = ~not_same_s;
        valid[14] = ~dec_s;
        valid[15] = ~inc_s;
        valid[16] = ~len_q[0];
        valid[17] = (distinct_s <= 3'd2);
        valid[18] = empty | (body_q[0] == body_q[last_idx_s]);
        valid[19] = pal_ok_s;
    end

    // Zero-latency read port; positions past the tail read as 0.
    always_comb begin
        read_over = ({1'b0, read_pos} >= len_q);
        if (read_over) begin
            read_val = 2'd0;
        end else begin
            read_val = body_q[read_pos];
        end
    end

endmodule

// File: tb/tb_caterpillar_rules.sv
// Directed self-checking bench for caterpillar_rules with hand-computed rule vectors.
module tb_caterpillar_rules;

    logic        clk;
    logic        rst_n;
    logic        update;
    logic        erase;
    logic [1:0]  color;
    logic [2:0]  read_pos;
    logic        empty;
    logic        full;
    logic [19:0] valid;
    logic [1:0]  read_val;
    logic        read_over;

    int checks;
    int failures;

    caterpillar_rules dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .update    (update),
        .erase     (erase),
        .color     (color),
        .read_pos  (read_pos),
        .empty     (empty),
        .full      (full),
        .valid     (valid),
        .read_val  (read_val),
        .read_over (read_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reset pulse placed between clock edges.
    task automatic apply_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // One command cycle; outputs are settled when this returns.
    task automatic do_cmd(input logic upd, input logic ers, input logic [1:0] col);
        update = upd;
        erase  = ers;
        color  = col;
        @(posedge clk);
        #1;
        update = 1'b0;
        erase  = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (empty !== 1'b1 || full !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags: empty=%b full=%b expected empty=1 full=0", empty, full);
        end
        checks++;
        if (valid !== 20'hFFFFF) begin
            failures++;
            $display("FAIL reset_valid: got %h expected fffff", valid);
        end
        for (int p = 0; p < 8; p++) begin
            read_pos = 3'(p);
            #1;
            checks++;
            if (read_over !== 1'b1 || read_val !== 2'd0) begin
                failures++;
                $display("FAIL reset_read pos=%0d: over=%b val=%0d expected over=1 val=0", p, read_over, read_val);
            end
        end
    endtask

    task automatic test_append();
        logic [1:0] seq [3];
        seq[0] = 2'd0; seq[1] = 2'd1; seq[2] = 2'd2;
        apply_reset();
        for (int i = 0; i < 3; i++) do_cmd(1'b1, 1'b0, seq[i]);
        for (int p = 0; p < 4; p++) begin
            read_pos = 3'(p);
            #1;
            checks++;
            if (p < 3 && (read_over !== 1'b0 || read_val !== seq[p])) begin
                failures++;
                $display("FAIL append_read pos=%0d: over=%b val=%0d expected over=0 val=%0d", p, read_over, read_val, seq[p]);
            end else if (p == 3 && (read_over !== 1'b1 || read_val !== 2'd0)) begin
                failures++;
                $display("FAIL append_read pos=3: over=%b val=%0d expected over=1 val=0", read_over, read_val);
            end
        end
        checks++;
        if (valid !== 20'h05418) begin
            failures++;
            $display("FAIL append_valid: got %h expected 05418", valid);
        end
        checks++;
        if (empty !== 1'b0 || full !== 1'b0) begin
            failures++;
            $display("FAIL append_flags: empty=%b full=%b expected 0 0", empty, full);
        end
    endtask

    task automatic test_palindrome_erase();
        apply_reset();
        do_cmd(1'b1, 1'b0, 2'd1);
        do_cmd(1'b1, 1'b0, 2'd2);
        do_cmd(1'b1, 1'b0, 2'd1);
        checks++;
        if (valid !== 20'hE1229) begin
            failures++;
            $display("FAIL palindrome_valid: got %h expected e1229", valid);
        end
        do_cmd(1'b0, 1'b1, 2'd0);
        checks++;
        if (valid !== 20'h35429) begin
            failures++;
            $display("FAIL erase_valid: got %h expected 35429", valid);
        end
        read_pos = 3'd2;
        #1;
        checks++;
        if (read_over !== 1'b1 || read_val !== 2'd0) begin
            failures++;
            $display("FAIL erase_read pos=2: over=%b val=%0d expected over=1 val=0", read_over, read_val);
        end
        read_pos = 3'd1;
        #1;
        checks++;
        if (read_over !== 1'b0 || read_val !== 2'd2) begin
            failures++;
            $display("FAIL erase_read pos=1: over=%b val=%0d expected over=0 val=2", read_over, read_val);
        end
    endtask

    task automatic test_full();
        apply_reset();
        for (int i = 0; i < 8; i++) do_cmd(1'b1, 1'b0, 2'd3);
        checks++;
        if (full !== 1'b1 || valid !== 20'hFE887) begin
            failures++;
            $display("FAIL full_state: full=%b valid=%h expected full=1 valid=fe887", full, valid);
        end
        do_cmd(1'b1, 1'b0, 2'd0);
        read_pos = 3'd7;
        #1;
        checks++;
        if (full !== 1'b1 || read_val !== 2'd3 || read_over !== 1'b0 || valid !== 20'hFE887) begin
            failures++;
            $display("FAIL full_ignore: full=%b val=%0d over=%b valid=%h expected 1 3 0 fe887", full, read_val, read_over, valid);
        end
    endtask

    task automatic test_back_to_back();
        // Continues from the full body of eight color-3 segments.
        for (int i = 0; i < 6; i++) do_cmd(1'b0, 1'b1, 2'd0);
        do_cmd(1'b1, 1'b1, 2'd0);
        read_pos = 3'd0;
        #1;
        checks++;
        if (read_over !== 1'b0 || read_val !== 2'd3) begin
            failures++;
            $display("FAIL priority_pos0: over=%b val=%0d expected over=0 val=3", read_over, read_val);
        end
        read_pos = 3'd1;
        #1;
        checks++;
        if (read_over !== 1'b1 || read_val !== 2'd0) begin
            failures++;
            $display("FAIL priority_pos1: over=%b val=%0d expected over=1 val=0", read_over, read_val);
        end
        do_cmd(1'b0, 1'b1, 2'd0);
        do_cmd(1'b0, 1'b1, 2'd0);
        checks++;
        if (empty !== 1'b1 || full !== 1'b0 || valid !== 20'hFFFFF) begin
            failures++;
            $display("FAIL drain_empty: empty=%b full=%b valid=%h expected 1 0 fffff", empty, full, valid);
        end
        do_cmd(1'b1, 1'b0, 2'd2);
        read_pos = 3'd0;
        #1;
        checks++;
        if (read_over !== 1'b0 || read_val !== 2'd2 || empty !== 1'b0) begin
            failures++;
            $display("FAIL after_drain_pos0: over=%b val=%0d empty=%b expected 0 2 0", read_over, read_val, empty);
        end
        read_pos = 3'd1;
        #1;
        checks++;
        if (read_over !== 1'b1) begin
            failures++;
            $display("FAIL after_drain_pos1: over=%b expected 1", read_over);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        for (int i = 0; i < 5; i++) do_cmd(1'b1, 1'b0, 2'd1);
        read_pos = 3'd0;
        #1;
        checks++;
        if (read_over !== 1'b0 || read_val !== 2'd1) begin
            failures++;
            $display("FAIL pre_async: over=%b val=%0d expected 0 1", read_over, read_val);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (empty !== 1'b1 || full !== 1'b0 || valid !== 20'hFFFFF || read_over !== 1'b1 || read_val !== 2'd0) begin
            failures++;
            $display("FAIL async_reset: empty=%b full=%b valid=%h over=%b val=%0d expected 1 0 fffff 1 0",
                     empty, full, valid, read_over, read_val);
        end
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b1;
        update   = 1'b0;
        erase    = 1'b0;
        color    = 2'd0;
        read_pos = 3'd0;
        @(posedge clk);
        #1;
        test_reset();
        test_append();
        test_palindrome_erase();
        test_full();
        test_back_to_back();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
